redux_uart_tx: RTL and testbench

REDUX_UART_TX -- requirements
Module: redux_uart_tx

---
 rtl/redux_uart_tx.sv | 219 +++++++++++++++++++++
 tb/tb_redux_uart_tx.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/redux_uart_tx.sv
// redux_uart_tx
//   Memory-mapped UART transmitter for the redux core. A store to TX_ADDR
//   pushes a byte into a small FIFO. The FSM pops bytes and serialises
//   them as 8N1 frames, or 8E1 frames when REDUX_TX_PARITY_EN is defined.
//   Stores that arrive while the FIFO is full are dropped and counted.
//
// Configuration macro:
//   REDUX_TX_PARITY_EN - adds an even-parity bit after the data bits
//                        (11-bit frame instead of 10-bit).
//
// Parameters:
//   CLKS_PER_BIT - clk cycles per serial bit (>= 2)
//   TX_ADDR      - store address mapped to the transmitter
//   FIFO_DEPTH   - FIFO entries (power of two, >= 2)
//
// Ports:
//   clk       - rising-edge clock
//   rst_n     - asynchronous active-low reset
//   mem_we    - store strobe from the core
//   mem_addr  - store address
//   mem_wdata - store data
//   tx        - serial line, idle high
//   tx_busy   - a frame is on the line or bytes are queued
//   fifo_full - FIFO holds FIFO_DEPTH bytes
//   drop_cnt  - saturating count of stores rejected while full
module redux_uart_tx #(
  parameter int         CLKS_PER_BIT = 4,
  parameter logic [7:0] TX_ADDR      = 8'hFF,
  parameter int         FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mem_we,
  input  logic [7:0] mem_addr,
  input  logic [7:0] mem_wdata,
  output logic       tx,
  output logic       tx_busy,
  output logic       fifo_full,
  output logic [7:0] drop_cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int CYC_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [CYC_W-1:0] LAST_CYC = CYC_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef REDUX_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  // FIFO storage and control
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic [7:0]       drop_cnt_q;

  // Transmitter state
  state_t           state_q;
  logic [2:0]       bit_q;
  logic [CYC_W-1:0] cyc_q;
  logic [7:0]       shift_q;
  logic             tx_q;
`ifdef REDUX_TX_PARITY_EN
  logic             parity_q;
`endif

  logic store_hit, push, pop, fifo_empty, last_cyc, shift_en;

  assign store_hit  = mem_we && (mem_addr == TX_ADDR);
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FULL_CNT);
  assign push       = store_hit && !fifo_full;
  assign last_cyc   = (cyc_q == LAST_CYC);
  // A pop happens from IDLE, or on the last STOP cycle so back-to-back
  // frames leave no idle gap on the line.
  assign pop        = !fifo_empty &&
                      ((state_q == IDLE) || ((state_q == STOP) && last_cyc));
  assign shift_en   = (state_q == DATA) && last_cyc && (bit_q != 3'd7);

  assign tx       = tx_q;
  assign tx_busy  = (state_q != IDLE) || !fifo_empty;
  assign drop_cnt = drop_cnt_q;

  always_comb begin
    count_d = count_q;
    if (push && !pop)
      count_d = count_q + CNT_W'(1);
    else if (!push && pop)
      count_d = count_q - CNT_W'(1);
  end

  // FIFO payload is data only; emptiness is tracked by the reset counters.
  always_ff @(posedge clk) begin
    if (push)
      mem_q[wr_ptr_q] <= mem_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      drop_cnt_q <= '0;
    end else begin
      count_q <= count_d;
      if (push)
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      // A pop on the same edge does not rescue a store seen while full.
      if (store_hit && fifo_full && (drop_cnt_q != 8'hFF))
        drop_cnt_q <= drop_cnt_q + 8'd1;
    end
  end

  // Shift register: loaded on pop, shifted right after each data bit.
  always_ff @(posedge clk) begin
    if (pop) begin
      shift_q <= mem_q[rd_ptr_q];
`ifdef REDUX_TX_PARITY_EN
      parity_q <= ^mem_q[rd_ptr_q];
`endif
    end else if (shift_en) begin
      shift_q <= {1'b0, shift_q[7:1]};
    end
  end

  // Framing FSM; tx is registered so the line never glitches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bit_q   <= '0;
      cyc_q   <= '0;
      tx_q    <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          tx_q  <= 1'b1;
          cyc_q <= '0;
          bit_q <= '0;
          if (pop) begin
            state_q <= START;
            tx_q    <= 1'b0;
          end
        end
        START: begin
          if (last_cyc) begin
            cyc_q   <= '0;
            bit_q   <= '0;
            state_q <= DATA;
            tx_q    <= shift_q[0];
          end else begin
            cyc_q <= cyc_q + CYC_W'(1);
          end
        end
        DATA: begin
          if (last_cyc) begin
            cyc_q <= '0;
            if (bit_q == 3'd7) begin
              bit_q <= '0;
`ifdef REDUX_TX_PARITY_EN
              state_q <= PARITY;
              tx_q    <= parity_q;
`else
              state_q <= STOP;
              tx_q    <= 1'b1;
`endif
            end else begin
              bit_q <= bit_q + 3'd1;
              // shift_q moves right on this same edge, so bit 1 is next.
              tx_q  <= shift_q[1];
            end
          end else begin
            cyc_q <= cyc_q + CYC_W'(1);
          end
        end
`ifdef REDUX_TX_PARITY_EN
        PARITY: begin
          if (last_cyc) begin
            cyc_q   <= '0;
            state_q <= STOP;
            tx_q    <= 1'b1;
          end else begin
            cyc_q <= cyc_q + CYC_W'(1);
          end
        end
`endif
        STOP: begin
          if (last_cyc) begin
            cyc_q <= '0;
            if (pop) begin
              state_q <= START;
              tx_q    <= 1'b0;
            end else begin
              state_q <= IDLE;
              tx_q    <= 1'b1;
            end
          end else begin
            cyc_q <= cyc_q + CYC_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          cyc_q   <= '0;
          bit_q   <= '0;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_redux_uart_tx.sv
// Testbench for redux_uart_tx: a line-level model (byte queue plus a queue
// of per-cycle tx values) is compared against the DUT every cycle, and
// directed scenarios pin the model with hand-computed literals.
module tb_redux_uart_tx;
  localparam int         CPB   = 4;
  localparam int         DEPTH = 4;
  localparam logic [7:0] ADDR  = 8'hFF;
`ifdef REDUX_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       mem_we = 1'b0;
  logic [7:0] mem_addr = 8'h00;
  logic [7:0] mem_wdata = 8'h00;
  logic       tx, tx_busy, fifo_full;
  logic [7:0] drop_cnt;

  int checks = 0;
  int failures = 0;

  redux_uart_tx #(.CLKS_PER_BIT(CPB), .TX_ADDR(ADDR), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .tx(tx), .tx_busy(tx_busy),
    .fifo_full(fifo_full), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: queued bytes, and the tx value for each upcoming cycle.
  bit         wave[$];
  logic [7:0] mfifo[$];
  int         mdrop = 0;

  function automatic void append_frame(input logic [7:0] b);
    for (int i = 0; i < CPB; i++) wave.push_back(1'b0);
    for (int k = 0; k < 8; k++)
      for (int i = 0; i < CPB; i++) wave.push_back(b[k]);
`ifdef REDUX_TX_PARITY_EN
    for (int i = 0; i < CPB; i++) wave.push_back(^b);
`endif
    for (int i = 0; i < CPB; i++) wave.push_back(1'b1);
  endfunction

  initial begin
    int         pre;
    logic [7:0] b;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        wave.delete();
        mfifo.delete();
        mdrop = 0;
      end else begin
        pre = mfifo.size();
        if (wave.size() > 0) void'(wave.pop_front());
        // Line free (or just finishing its stop bit): next byte starts now.
        if (wave.size() == 0 && pre > 0) begin
          b = mfifo.pop_front();
          append_frame(b);
        end
        if (mem_we && mem_addr == ADDR) begin
          if (pre < DEPTH) mfifo.push_back(mem_wdata);
          else if (mdrop < 255) mdrop++;
        end
      end
    end
  end

  // Per-cycle compare against the model.
  initial begin
    forever begin
      @(negedge clk);
      check("tx",        tx,        (wave.size() > 0) ? 32'(wave[0]) : 32'd1);
      check("tx_busy",   tx_busy,   32'((wave.size() > 0) || (mfifo.size() > 0)));
      check("fifo_full", fifo_full, 32'(mfifo.size() == DEPTH));
      check("drop_cnt",  drop_cnt,  32'(mdrop));
    end
  end

  // Called on a negedge; applies one store for the next rising edge.
  task automatic drive(input logic [7:0] a, input logic [7:0] d);
    mem_we = 1'b1;
    mem_addr = a;
    mem_wdata = d;
    @(negedge clk);
  endtask

  // Store one byte from idle; sample the middle of each bit slot.
  task automatic send_capture(input logic [7:0] d, output logic [10:0] bits, output int blen);
    bits = '0;
    blen = 0;
    drive(ADDR, d);
    mem_we = 1'b0;
    for (int i = 0; i <= FRAME_BITS * CPB + 3; i++) begin
      if (tx_busy) blen++;
      if (i >= 3 && ((i - 3) % CPB) == 0 && ((i - 3) / CPB) < 11)
        bits[(i - 3) / CPB] = tx;
      @(negedge clk);
    end
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while (tx_busy && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", tx_busy, 32'd0);
  endtask

  initial begin
    logic [10:0] bits;
    int          blen;
    int          n;

    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_tx", tx, 32'd1);
    check("rst_busy", tx_busy, 32'd0);
    check("rst_full", fifo_full, 32'd0);
    check("rst_drop", drop_cnt, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single byte 0x55: start, 1,0,1,0,1,0,1,0, [parity 0], stop.
    send_capture(8'h55, bits, blen);
`ifdef REDUX_TX_PARITY_EN
    check("frame_55", bits, 32'h4AA);
    check("frame_len_55", blen, 32'd45);
`else
    check("frame_55", bits, 32'h6AA);
    check("frame_len_55", blen, 32'd41);
`endif

`ifdef REDUX_TX_PARITY_EN
    send_capture(8'h07, bits, blen);
    check("parity_07", bits[9], 32'd1);
    check("frame_07", bits, 32'h60E);
    send_capture(8'h03, bits, blen);
    check("parity_03", bits[9], 32'd0);
    check("frame_len_03", blen, 32'd45);
`endif

    // Store to another address: nothing happens.
    drive(8'h10, 8'hA3);
    mem_we = 1'b0;
    repeat (3) @(negedge clk);
    check("other_tx", tx, 32'd1);
    check("other_busy", tx_busy, 32'd0);
    check("other_full", fifo_full, 32'd0);

    // Six back-to-back stores: one popped, four queued, one dropped.
    for (int i = 0; i < 6; i++) drive(ADDR, 8'(8'h30 + i));
    mem_we = 1'b0;
    check("burst_full", fifo_full, 32'd1);
    check("burst_drop", drop_cnt, 32'd1);
    // Busy from the cycle after the first store through five frames,
    // less the five busy cycles already spent inside the burst.
    n = 0;
    while (tx_busy && n < 2000) begin
      n++;
      @(negedge clk);
    end
    check("burst_busy_len", n, 32'(1 + 5 * FRAME_BITS * CPB - 5));

    // Reset during DATA with two bytes queued.
    for (int i = 0; i < 3; i++) drive(ADDR, 8'(8'hC0 + i));
    mem_we = 1'b0;
    repeat (6) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_tx", tx, 32'd1);
    check("midrst_busy", tx_busy, 32'd0);
    check("midrst_full", fifo_full, 32'd0);
    check("midrst_drop", drop_cnt, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    check("postrst_tx", tx, 32'd1);
    check("postrst_busy", tx_busy, 32'd0);

    // Latency after reset: tx low after the second edge.
    drive(ADDR, 8'h5A);
    mem_we = 1'b0;
    check("lat_edge1", tx, 32'd1);
    @(negedge clk);
    check("lat_edge2", tx, 32'd0);
    wait_idle(200);

    // Long run of stores while mostly full: drop count saturates.
    for (int i = 0; i < 305; i++) drive(ADDR, 8'(i));
    mem_we = 1'b0;
    check("drop_sat", drop_cnt, 32'd255);
    wait_idle(2000);
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
